uart_hex_word: RTL and testbench

UART_HEX_WORD -- requirements
Module: uart_hex_word

---
 rtl/uart_hex_word.sv | 149 ++++++++++++++
 tb/tb_uart_hex_word.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_word.sv
// uart_hex_word: formats a word of DIGITS hex nibbles into lowercase ASCII
// bytes for a downstream uart_tx. Each word ends with a tail sequence.
// Build option: define UART_HEX_CRLF_EN for a CR LF tail (0x0D 0x0A);
// without it the tail is a single space (0x20).
// out_strobe is combinational on out_ready, so a byte is only offered while
// the transmitter is ready. out_data carries the byte in the strobe cycle and
// holds it until the next strobe.

module uart_hex_word #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_strobe,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_strobe,
    input  logic                  out_ready
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIGIT,
        TAIL
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [4*DIGITS-1:0] r_word;
    logic [CW-1:0]      r_count;
    logic               r_prevStrobe;
    logic               r_rstDone;
    logic [7:0]         r_outData;
    logic               w_emit;
    logic               w_accept;
    logic               w_tailLast;
    logic [3:0]         w_nib;
    logic [7:0]         w_byte;
    logic [CW-1:0]      w_nibIdx;

`ifdef UART_HEX_CRLF_EN
    logic               r_tailIdx;
`endif

    // State register; reset forces IDLE, which also aborts any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: advance only when a byte is actually handed over.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = DIGIT;
            DIGIT:   if (w_emit && (r_count == LAST_DIGIT)) w_nextState = TAIL;
            TAIL:    if (w_emit && w_tailLast) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic: ready gating, strobe spacing and the byte being offered.
    always_comb begin
        in_ready   = (r_state == IDLE) && r_rstDone;
        w_accept   = in_strobe && in_ready;
        w_emit     = (r_state != IDLE) && out_ready && !r_prevStrobe;
        out_strobe = w_emit;
        out_data   = w_emit ? w_byte : r_outData;
    end

    // Pick the current nibble, most significant first.
    always_comb begin
        w_nibIdx = LAST_DIGIT - r_count;
        w_nib    = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_nibIdx == CW'(i)) begin
                w_nib = r_word[4*i +: 4];
            end
        end
    end

    // Translate the nibble to lowercase ASCII, or supply the tail byte.
`ifdef UART_HEX_CRLF_EN
    always_comb begin
        w_tailLast = r_tailIdx;
        if (r_state == TAIL) begin
            w_byte = r_tailIdx ? 8'h0A : 8'h0D;
        end else if (w_nib < 4'd10) begin
            w_byte = {4'h3, w_nib};
        end else begin
            w_byte = 8'h57 + {4'h0, w_nib};
        end
    end
`else
    always_comb begin
        w_tailLast = 1'b1;
        if (r_state == TAIL) begin
            w_byte = 8'h20;
        end else if (w_nib < 4'd10) begin
            w_byte = {4'h3, w_nib};
        end else begin
            w_byte = 8'h57 + {4'h0, w_nib};
        end
    end
`endif

    // Datapath: capture the word, count digits, remember the last byte and
    // strobe, and hold off in_ready until the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word       <= '0;
            r_count      <= '0;
            r_prevStrobe <= 1'b0;
            r_outData    <= 8'h00;
            r_rstDone    <= 1'b0;
`ifdef UART_HEX_CRLF_EN
            r_tailIdx    <= 1'b0;
`endif
        end else begin
            r_rstDone    <= 1'b1;
            r_prevStrobe <= w_emit;
            if (w_emit) begin
                r_outData <= w_byte;
            end
            if (w_accept) begin
                r_word    <= in_data;
                r_count   <= '0;
`ifdef UART_HEX_CRLF_EN
                r_tailIdx <= 1'b0;
`endif
            end else if (w_emit && (r_state == DIGIT)) begin
                r_count <= r_count + 1'b1;
            end
`ifdef UART_HEX_CRLF_EN
            else if (w_emit && (r_state == TAIL)) begin
                r_tailIdx <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_hex_word.sv
// tb_uart_hex_word: directed scenarios for uart_hex_word with DIGITS=8 and
// DIGITS=2 instances. Tail bytes follow UART_HEX_CRLF_EN if defined.

module tb_uart_hex_word;

    logic clk = 1'b0;
    logic reset;

    logic [31:0] in_data8;
    logic        in_strobe8, in_ready8, out_strobe8, out_ready8;
    logic [7:0]  out_data8;

    logic [7:0]  in_data2;
    logic        in_strobe2, in_ready2, out_strobe2, out_ready2;
    logic [7:0]  out_data2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] q8[$];
    logic [7:0] q2[$];
    logic [7:0] tailQ[$];
    int         t2[$];
    int         consec8 = 0, notReady8 = 0, lastStrobe8 = 0;
    int         consec2 = 0, notReady2 = 0;
    bit         prev8 = 1'b0, prev2 = 1'b0;

    uart_hex_word #(.DIGITS(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_data(in_data8), .in_strobe(in_strobe8), .in_ready(in_ready8),
        .out_data(out_data8), .out_strobe(out_strobe8), .out_ready(out_ready8)
    );

    uart_hex_word #(.DIGITS(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_data(in_data2), .in_strobe(in_strobe2), .in_ready(in_ready2),
        .out_data(out_data2), .out_strobe(out_strobe2), .out_ready(out_ready2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Byte monitor: records emitted bytes and strobe-rule violations.
    always @(negedge clk) begin
        if (out_strobe8) begin
            q8.push_back(out_data8);
            lastStrobe8 = cyc;
            if (prev8) consec8++;
            if (!out_ready8) notReady8++;
        end
        prev8 = out_strobe8;
        if (out_strobe2) begin
            q2.push_back(out_data2);
            t2.push_back(cyc);
            if (prev2) consec2++;
            if (!out_ready2) notReady2++;
        end
        prev2 = out_strobe2;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic sendWord8(input logic [31:0] d);
        in_data8   = d;
        in_strobe8 = 1'b1;
        step();
        in_strobe8 = 1'b0;
    endtask

    task automatic waitIdle8(output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (in_ready8) begin
                timedOut = 1'b0;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if (in_ready8 !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=0", in_ready8); end
        total++;
        if (out_strobe8 !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_strobe got=%b want=0", out_strobe8); end
        total++;
        if (out_data8 !== 8'h00) begin bad++; $display("[TB] FAIL rst_out_data got=%h want=00", out_data8); end
        reset = 1'b0;
        #1;
        total++;
        if (in_ready8 !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready_before_edge got=%b want=0", in_ready8); end
        step();
        total++;
        if (in_ready8 !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready_after_edge got=%b want=1", in_ready8); end
        total++;
        if (in_ready2 !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready2 got=%b want=1", in_ready2); end
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        logic [7:0] got;
        bit to;
        exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h61, 8'h62, 8'h63, 8'h64};
        foreach (tailQ[k]) exp.push_back(tailQ[k]);
        q8.delete();
        consec8 = 0;
        in_data8   = 32'h0123abcd;
        in_strobe8 = 1'b1;
        total++;
        if (out_strobe8 !== 1'b0) begin bad++; $display("[TB] FAIL basic_no_strobe_idle got=%b want=0", out_strobe8); end
        step();
        in_strobe8 = 1'b0;
        total++;
        if (in_ready8 !== 1'b0) begin bad++; $display("[TB] FAIL basic_ready_drop got=%b want=0", in_ready8); end
        total++;
        if (out_strobe8 !== 1'b1 || out_data8 !== 8'h30) begin
            bad++; $display("[TB] FAIL basic_first_byte got=%b/%h want=1/30", out_strobe8, out_data8);
        end
        waitIdle8(to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL basic_timeout got=timeout want=idle"); end
        total++;
        if (cyc !== lastStrobe8 + 1) begin bad++; $display("[TB] FAIL basic_ready_timing got=%0d want=%0d", cyc, lastStrobe8 + 1); end
        total++;
        if (q8.size() != exp.size()) begin bad++; $display("[TB] FAIL basic_len got=%0d want=%0d", q8.size(), exp.size()); end
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q8.size()) ? q8[k] : 8'hxx;
            total++;
            if (got !== exp[k]) begin bad++; $display("[TB] FAIL basic_byte%0d got=%h want=%h", k, got, exp[k]); end
        end
        total++;
        if (consec8 != 0) begin bad++; $display("[TB] FAIL basic_consec got=%0d want=0", consec8); end
    endtask

    task automatic test_all_f();
        logic [7:0] exp[$];
        logic [7:0] got;
        bit to;
        for (int k = 0; k < 8; k++) exp.push_back(8'h66);
        foreach (tailQ[k]) exp.push_back(tailQ[k]);
        q8.delete();
        sendWord8(32'hffffffff);
        waitIdle8(to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL allf_timeout got=timeout want=idle"); end
        total++;
        if (cyc !== lastStrobe8 + 1) begin bad++; $display("[TB] FAIL allf_ready_timing got=%0d want=%0d", cyc, lastStrobe8 + 1); end
        total++;
        if (q8.size() != exp.size()) begin bad++; $display("[TB] FAIL allf_len got=%0d want=%0d", q8.size(), exp.size()); end
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q8.size()) ? q8[k] : 8'hxx;
            total++;
            if (got !== exp[k]) begin bad++; $display("[TB] FAIL allf_byte%0d got=%h want=%h", k, got, exp[k]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp[$];
        logic [7:0] got;
        int base;
        bit to;
        exp = '{8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        foreach (tailQ[k]) exp.push_back(tailQ[k]);
        q8.delete();
        notReady8 = 0;
        sendWord8(32'h89abcdef);
        for (int i = 0; i < 50 && q8.size() < 3; i++) step();
        total++;
        if (q8.size() != 3) begin bad++; $display("[TB] FAIL stall_reach3 got=%0d want=3", q8.size()); end
        out_ready8 = 1'b0;
        #1;
        total++;
        if (out_strobe8 !== 1'b0) begin bad++; $display("[TB] FAIL stall_strobe_low got=%b want=0", out_strobe8); end
        base = q8.size();
        for (int i = 0; i < 50; i++) step();
        total++;
        if (q8.size() != base) begin bad++; $display("[TB] FAIL stall_no_bytes got=%0d want=%0d", q8.size(), base); end
        total++;
        if (in_ready8 !== 1'b0) begin bad++; $display("[TB] FAIL stall_busy got=%b want=0", in_ready8); end
        out_ready8 = 1'b1;
        waitIdle8(to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL stall_timeout got=timeout want=idle"); end
        total++;
        if (notReady8 != 0) begin bad++; $display("[TB] FAIL stall_strobe_not_ready got=%0d want=0", notReady8); end
        total++;
        if (q8.size() != exp.size()) begin bad++; $display("[TB] FAIL stall_len got=%0d want=%0d", q8.size(), exp.size()); end
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q8.size()) ? q8[k] : 8'hxx;
            total++;
            if (got !== exp[k]) begin bad++; $display("[TB] FAIL stall_byte%0d got=%h want=%h", k, got, exp[k]); end
        end
    endtask

    task automatic test_ignore();
        logic [7:0] exp[$];
        logic [7:0] got;
        bit to;
        for (int k = 0; k < 8; k++) exp.push_back(8'h30);
        foreach (tailQ[k]) exp.push_back(tailQ[k]);
        q8.delete();
        sendWord8(32'h00000000);
        step();
        step();
        in_data8   = 32'hdeadbeef;
        in_strobe8 = 1'b1;
        total++;
        if (in_ready8 !== 1'b0) begin bad++; $display("[TB] FAIL ignore_busy got=%b want=0", in_ready8); end
        step();
        in_strobe8 = 1'b0;
        waitIdle8(to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL ignore_timeout got=timeout want=idle"); end
        for (int i = 0; i < 10; i++) step();
        total++;
        if (q8.size() != exp.size()) begin bad++; $display("[TB] FAIL ignore_len got=%0d want=%0d", q8.size(), exp.size()); end
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q8.size()) ? q8[k] : 8'hxx;
            total++;
            if (got !== exp[k]) begin bad++; $display("[TB] FAIL ignore_byte%0d got=%h want=%h", k, got, exp[k]); end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp[$];
        logic [7:0] got;
        bit to;
        exp = '{8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h30};
        foreach (tailQ[k]) exp.push_back(tailQ[k]);
        q8.delete();
        sendWord8(32'h12345678);
        for (int i = 0; i < 50 && q8.size() < 3; i++) step();
        total++;
        if (q8.size() != 3) begin bad++; $display("[TB] FAIL abort_reach3 got=%0d want=3", q8.size()); end
        reset = 1'b1;
        #1;
        total++;
        if (out_strobe8 !== 1'b0) begin bad++; $display("[TB] FAIL abort_strobe got=%b want=0", out_strobe8); end
        total++;
        if (out_data8 !== 8'h00) begin bad++; $display("[TB] FAIL abort_data got=%h want=00", out_data8); end
        total++;
        if (in_ready8 !== 1'b0) begin bad++; $display("[TB] FAIL abort_ready_in_reset got=%b want=0", in_ready8); end
        step();
        step();
        reset = 1'b0;
        q8.delete();
        for (int i = 0; i < 30; i++) step();
        total++;
        if (q8.size() != 0) begin bad++; $display("[TB] FAIL abort_leftover got=%0d want=0", q8.size()); end
        total++;
        if (in_ready8 !== 1'b1) begin bad++; $display("[TB] FAIL abort_ready got=%b want=1", in_ready8); end
        sendWord8(32'h9abcdef0);
        waitIdle8(to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL abort_timeout got=timeout want=idle"); end
        total++;
        if (q8.size() != exp.size()) begin bad++; $display("[TB] FAIL abort_len got=%0d want=%0d", q8.size(), exp.size()); end
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q8.size()) ? q8[k] : 8'hxx;
            total++;
            if (got !== exp[k]) begin bad++; $display("[TB] FAIL abort_byte%0d got=%h want=%h", k, got, exp[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] word[$];
        int wlen;
        bit to;
        word = '{8'h61, 8'h35};
        foreach (tailQ[k]) word.push_back(tailQ[k]);
        wlen = word.size();
        q2.delete();
        t2.delete();
        consec2   = 0;
        notReady2 = 0;
        in_data2   = 8'ha5;
        in_strobe2 = 1'b1;
        for (int i = 0; i < 200 && q2.size() < 3 * wlen; i++) step();
        in_strobe2 = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready2) begin
                to = 1'b0;
                break;
            end
            step();
        end
        total++;
        if (to) begin bad++; $display("[TB] FAIL b2b_timeout got=timeout want=idle"); end
        total++;
        if (q2.size() < 3 * wlen || (q2.size() % wlen) != 0) begin
            bad++; $display("[TB] FAIL b2b_len got=%0d want=multiple of %0d, at least %0d", q2.size(), wlen, 3 * wlen);
        end
        for (int k = 0; k < q2.size(); k++) begin
            total++;
            if (q2[k] !== word[k % wlen]) begin bad++; $display("[TB] FAIL b2b_byte%0d got=%h want=%h", k, q2[k], word[k % wlen]); end
        end
        for (int k = 1; k < t2.size(); k++) begin
            total++;
            if (t2[k] - t2[k-1] != 2) begin bad++; $display("[TB] FAIL b2b_gap%0d got=%0d want=2", k, t2[k] - t2[k-1]); end
        end
        total++;
        if (consec2 != 0 || notReady2 != 0) begin
            bad++; $display("[TB] FAIL b2b_strobe_rule got=%0d/%0d want=0/0", consec2, notReady2);
        end
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
`ifdef UART_HEX_CRLF_EN
        tailQ = '{8'h0D, 8'h0A};
`else
        tailQ = '{8'h20};
`endif
        reset      = 1'b1;
        in_data8   = '0;
        in_strobe8 = 1'b0;
        out_ready8 = 1'b1;
        in_data2   = '0;
        in_strobe2 = 1'b0;
        out_ready2 = 1'b1;
        test_reset();
        test_basic();
        test_all_f();
        test_stall();
        test_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
